nmac_gmii_rx_pack: RTL and testbench

Receive-side front end of the NMAC port. Captures GMII bytes, strips preamble and SFD, and packs each frame into 128-bit tagged words for the 139-bit packet FIFO that feeds CRC checking. At end of frame it writes exactly one entry into the 1-bit valid FIFO. The entry flags frames that carried a GMII error, violated length limits, or were truncated.

---
 rtl/nmac_pkt_pkg.sv | 22 ++
 rtl/nmac_byte_packer.sv | 77 +++++++
 rtl/nmac_gmii_rx_pack.sv | 103 ++++++++++
 tb/tb_nmac_gmii_rx_pack.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nmac_pkt_pkg.sv
// Packet-word layout shared by the NMAC receive, CRC-check and transmit stages.
// A word is {tag, valid bytes-1, reserved, 128-bit data}, first byte in the top lane.
package nmac_pkt_pkg;
  localparam int PKT_W   = 139;
  localparam int DATA_W  = 128;
  localparam int TAG_HI  = 138;
  localparam int TAG_LO  = 136;
  localparam int BCNT_HI = 135;
  localparam int BCNT_LO = 132;

  localparam logic [2:0] TAG_HEAD = 3'b101;
  localparam logic [2:0] TAG_MID  = 3'b100;
  localparam logic [2:0] TAG_TAIL = 3'b110;
  localparam logic [2:0] TAG_ONE  = 3'b111;

  typedef struct packed {
    logic [2:0]        tag;
    logic [3:0]        bcnt;
    logic [3:0]        rsvd;
    logic [DATA_W-1:0] data;
  } pkt_word_t;
endpackage

// File: rtl/nmac_byte_packer.sv
// Packs frame bytes into 16-byte words; one completed word is held back so the
// last word of a frame can always leave with a tail tag.
module nmac_byte_packer
  import nmac_pkt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_i,
  input  logic             flush_i,
  output logic             pkt_wrreq_o,
  output logic [PKT_W-1:0] pkt_o
);
  logic [3:0]        cnt_q;
  logic              pend_vld_q;
  logic              first_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] pend_q;
  logic              wrreq_q;
  pkt_word_t         pkt_q;

  // A fresh word starts cleared so a short tail carries zeros in its unused lanes.
  always_comb begin
    word_d = (cnt_q == 4'd0) ? '0 : word_q;
    word_d[{~cnt_q, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      first_q    <= 1'b1;
      word_q     <= '0;
      pend_q     <= '0;
      wrreq_q    <= 1'b0;
      pkt_q      <= '0;
    end else begin
      wrreq_q <= 1'b0;
      if (start_i) begin
        cnt_q      <= '0;
        pend_vld_q <= 1'b0;
        first_q    <= 1'b1;
      end else if (byte_vld_i) begin
        word_q <= word_d;
        cnt_q  <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          pend_q     <= word_d;
          pend_vld_q <= 1'b1;
        end
        if (cnt_q == 4'd0 && pend_vld_q) begin
          wrreq_q    <= 1'b1;
          pkt_q.tag  <= first_q ? TAG_HEAD : TAG_MID;
          pkt_q.bcnt <= 4'hF;
          pkt_q.rsvd <= '0;
          pkt_q.data <= pend_q;
          pend_vld_q <= 1'b0;
          first_q    <= 1'b0;
        end
      end else if (flush_i) begin
        // cnt_q-1 wraps to F when the tail is a completed pending word.
        wrreq_q    <= 1'b1;
        pkt_q.tag  <= first_q ? TAG_ONE : TAG_TAIL;
        pkt_q.bcnt <= cnt_q - 4'd1;
        pkt_q.rsvd <= '0;
        pkt_q.data <= (cnt_q != 4'd0) ? word_q : (pend_vld_q ? pend_q : '0);
        cnt_q      <= '0;
        pend_vld_q <= 1'b0;
        first_q    <= 1'b1;
      end
    end
  end

  assign pkt_wrreq_o = wrreq_q;
  assign pkt_o       = pkt_q;
endmodule

// File: rtl/nmac_gmii_rx_pack.sv
// GMII receive front end: preamble/SFD strip, admission, length/error tracking,
// one valid-FIFO entry per admitted frame and frame/bad counters.
module nmac_gmii_rx_pack
  import nmac_pkt_pkg::*;
#(
  parameter int unsigned MIN_LEN     = 64,
  parameter int unsigned MAX_LEN     = 1518,
  parameter logic [7:0]  FIFO_THRESH = 8'd160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic             out_pkt_wrreq,
  output logic [PKT_W-1:0] out_pkt,
  input  logic [7:0]       out_pkt_usedw,
  output logic             out_valid_wrreq,
  output logic             out_valid,
  output logic [31:0]      rx_frame_cnt,
  output logic [31:0]      rx_bad_cnt
);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t      state_q;
  logic [10:0] len_q;
  logic        err_q;
  logic        vwr_q;
  logic        vld_q;
  logic [31:0] frame_cnt_q;
  logic [31:0] bad_cnt_q;

  logic sfd, admit, at_max, pk_start, pk_byte, pk_flush, frame_bad;

  assign sfd      = (state_q == S_PRE) && gmii_rx_dv && (gmii_rxd == 8'hD5);
  assign admit    = out_pkt_usedw <= FIFO_THRESH;
  assign at_max   = len_q == MAX_L;
  assign pk_start = sfd && admit;
  assign pk_byte  = (state_q == S_DATA) && gmii_rx_dv && !at_max;
  assign pk_flush = (state_q == S_DATA) && (!gmii_rx_dv || at_max);
  // At flush time a still-high rx_dv means the frame is being truncated.
  assign frame_bad = err_q || (len_q < MIN_L) || gmii_rx_dv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      err_q       <= 1'b0;
      vwr_q       <= 1'b0;
      vld_q       <= 1'b0;
      frame_cnt_q <= '0;
      bad_cnt_q   <= '0;
    end else begin
      vwr_q <= 1'b0;
      vld_q <= 1'b0;
      case (state_q)
        S_IDLE: if (gmii_rx_dv) state_q <= S_PRE;
        S_PRE: begin
          if (!gmii_rx_dv) begin
            state_q <= S_IDLE;
          end else if (sfd) begin
            state_q <= admit ? S_DATA : S_DROP;
            len_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        S_DATA: begin
          if (pk_flush) begin
            vwr_q       <= 1'b1;
            vld_q       <= !frame_bad;
            frame_cnt_q <= frame_cnt_q + 32'd1;
            if (frame_bad) bad_cnt_q <= bad_cnt_q + 32'd1;
            state_q     <= gmii_rx_dv ? S_DROP : S_IDLE;
          end else begin
            if (len_q != 11'h7FF) len_q <= len_q + 11'd1;
            err_q <= err_q | gmii_rx_er;
          end
        end
        S_DROP: if (!gmii_rx_dv) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  nmac_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .start_i    (pk_start),
    .byte_vld_i (pk_byte),
    .byte_i     (gmii_rxd),
    .flush_i    (pk_flush),
    .pkt_wrreq_o(out_pkt_wrreq),
    .pkt_o      (out_pkt)
  );

  assign out_valid_wrreq = vwr_q;
  assign out_valid       = vld_q;
  assign rx_frame_cnt    = frame_cnt_q;
  assign rx_bad_cnt      = bad_cnt_q;
endmodule

// File: tb/tb_nmac_gmii_rx_pack.sv
// Randomized frame stimulus with a queue scoreboard; expected words come from
// slicing each frame into 16-byte chunks, independent of the packer internals.
module tb_nmac_gmii_rx_pack;
  import nmac_pkt_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rxd = 8'h00;
  logic         dv = 1'b0;
  logic         er = 1'b0;
  logic [7:0]   usedw = 8'h00;
  logic         pkt_wr;
  logic [138:0] pkt;
  logic         val_wr;
  logic         val;
  logic [31:0]  fcnt;
  logic [31:0]  bcnt;

  always #4 clk = ~clk;

  nmac_gmii_rx_pack dut (
    .clk            (clk),
    .reset          (rst),
    .gmii_rxd       (rxd),
    .gmii_rx_dv     (dv),
    .gmii_rx_er     (er),
    .out_pkt_wrreq  (pkt_wr),
    .out_pkt        (pkt),
    .out_pkt_usedw  (usedw),
    .out_valid_wrreq(val_wr),
    .out_valid      (val),
    .rx_frame_cnt   (fcnt),
    .rx_bad_cnt     (bcnt)
  );

  typedef struct {
    logic ok;
    int   frames;
    int   bad;
  } vexp_t;

  logic [138:0] exp_pkt[$];
  vexp_t        exp_val[$];
  int           exp_tcyc[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           m_frames = 0;
  int           m_bad = 0;
  logic [7:0]   fb[0:2047];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard.
  always @(posedge clk) begin
    vexp_t e;
    cyc++;
    #1;
    if (pkt_wr) begin
      if (exp_pkt.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pkt_write actual=%0h expected=none", pkt);
      end else chk("pkt_word", pkt, exp_pkt.pop_front());
    end
    if (val_wr) begin
      if (exp_val.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_write actual=%0b expected=none", val);
      end else begin
        e = exp_val.pop_front();
        chk("out_valid", val, e.ok);
        chk("rx_frame_cnt", fcnt, e.frames);
        chk("rx_bad_cnt", bcnt, e.bad);
        chk("tail_with_valid", pkt_wr & (pkt[138:137] == 2'b11), 1);
        if (exp_tcyc.size() != 0) chk("tail_latency", cyc, exp_tcyc.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    dv = v; rxd = d; er = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pkt_wr"}, pkt_wr, 0);
    chk({tag, "_pkt"}, pkt, 0);
    chk({tag, "_val_wr"}, val_wr, 0);
    chk({tag, "_val"}, val, 0);
    chk({tag, "_fcnt"}, fcnt, 0);
    chk({tag, "_bcnt"}, bcnt, 0);
  endtask

  // rst_at >= 0 asserts reset instead of sending byte rst_at.
  task automatic send_frame(input int len, input int erpos, input logic [7:0] uw, input int rst_at);
    int        le, nw, npre, idx;
    logic      adm, bad;
    pkt_word_t pw;
    for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
    usedw = uw;
    adm = (uw <= 8'd160);
    le = (len > 1518) ? 1518 : len;
    if (adm) begin
      nw = (rst_at >= 0) ? (rst_at - 1) / 16 : (le + 15) / 16;
      for (int wi = 0; wi < nw; wi++) begin
        pw = '0;
        for (int b = 0; b < 16; b++) begin
          idx = wi * 16 + b;
          if (idx < le) pw.data[8*(15-b) +: 8] = fb[idx];
        end
        if (rst_at < 0 && nw == 1) pw.tag = TAG_ONE;
        else if (wi == 0) pw.tag = TAG_HEAD;
        else if (rst_at < 0 && wi == nw - 1) pw.tag = TAG_TAIL;
        else pw.tag = TAG_MID;
        pw.bcnt = (rst_at < 0 && wi == nw - 1) ? 4'((le - 1) % 16) : 4'hF;
        exp_pkt.push_back(pw);
      end
      if (rst_at < 0) begin
        bad = (len < 64) || (len > 1518) || (erpos >= 0 && erpos < le);
        m_frames++;
        if (bad) m_bad++;
        exp_val.push_back('{!bad, m_frames, m_bad});
      end
    end
    npre = $urandom_range(1, 7);
    repeat (npre) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1; dv = 1'b0; er = 1'b0;
        #1;
        check_zero_outputs("reset_midframe");
        chk("abort_words_written", exp_pkt.size(), 0);
        m_frames = 0; m_bad = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        return;
      end
      drive(1'b1, fb[i], i == erpos);
      if (adm && i == 1518) exp_tcyc.push_back(cyc + 1);
    end
    drive(1'b0, 8'($urandom), 1'b0);
    if (adm && len <= 1518) exp_tcyc.push_back(cyc + 1);
    idle($urandom_range(1, 4));
    chk("frame_cnt_after", fcnt, m_frames);
    chk("bad_cnt_after", bcnt, m_bad);
  endtask

  initial begin
    #700000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int len, erpos;
    logic [7:0] uw;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(3);

    send_frame(64, -1, 8'd0, -1);
    send_frame(65, -1, 8'd10, -1);
    send_frame(60, -1, 8'd20, -1);
    send_frame(10, -1, 8'd0, -1);
    send_frame(16, -1, 8'd0, -1);
    send_frame(1600, -1, 8'd5, -1);
    send_frame(100, 30, 8'd0, -1);
    send_frame(64, -1, 8'd200, -1);
    send_frame(64, -1, 8'd161, -1);
    send_frame(80, -1, 8'd160, -1);

    // Preamble aborts: nothing may be written.
    repeat (3) drive(1'b1, 8'h55, 1'b0);
    idle(3);
    drive(1'b1, 8'h55, 1'b0);
    idle(3);

    send_frame(200, -1, 8'd0, 40);
    send_frame(64, -1, 8'd0, -1);

    for (int k = 0; k < 40; k++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1400, 1600) : $urandom_range(1, 200);
      erpos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      uw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 160));
      send_frame(len, erpos, uw, -1);
    end

    idle(6);
    chk("pkt_queue_drained", exp_pkt.size(), 0);
    chk("valid_queue_drained", exp_val.size(), 0);
    chk("tail_queue_drained", exp_tcyc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
